apb_opb_bridge: RTL and testbench
=================================

// Module: apb_opb_bridge
// PURPOSE
//  APB3 slave on the MSS fabric interface; converts each APB transfer into one single-cycle OPB_RE/OPB_WE
//  strobe with a stable OPB_ADDR/OPB_DI.
//  Drives the OPB address decoder directly and returns OPB_DO read data to the processor after a fixed
//  wait count. One transfer at a time, no posting.
// PARAMETERS
//  ADDR_W   24  OPB address width; OPB_ADDR = PADDR[ADDR_W-1:0] (byte address, no shift)
//  DATA_W   32  APB/OPB data width
//  RD_WAIT   2  cycles between OPB_RE strobe and OPB_DO sample (1..15)
//  WR_WAIT   0  extra cycles after OPB_WE strobe before PREADY (0..15)
// PORTS
//  SYSCLK      in   1       system clock; all logic on rising edge
//  SYSRST_N    in   1       asynchronous active-low reset
//  PSEL        in   1       APB select
//  PENABLE     in   1       APB access phase
//  PWRITE      in   1       1=write, 0=read
//  PADDR       in   32      APB byte address
//  PWDATA      in   DATA_W  APB write data
//  PRDATA      out  DATA_W  registered read data
//  PREADY      out  1       one-cycle transfer-complete
//  PSLVERR     out  1       error response (macro only; tied 0 otherwise)
//  OPB_ADDR    out  ADDR_W  registered address to decoder
//  OPB_DI      out  DATA_W  registered write data to peripherals
//  OPB_RE      out  1       one-cycle read strobe
//  OPB_WE      out  1       one-cycle write strobe
//  OPB_DO      in   DATA_W  OR-combined peripheral read data
//  OPB_HIT     in   1       OR of all decoder enables (used only with macro)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, wait counter 0.
//  FSM IDLE->STROBE->WAIT->DONE->IDLE.
//  IDLE: PSEL=1 captures PADDR, PWDATA, PWRITE into OPB_ADDR/OPB_DI/dir; ->STROBE.
//   A PENABLE=1 in that same cycle is accepted as well, not treated as an error.
//  STROBE: exactly one cycle of OPB_WE (dir=1) or OPB_RE (dir=0); load counter with WR_WAIT or RD_WAIT;
//   ->WAIT, or ->DONE when the count is 0.
//  WAIT: decrement each cycle; at 0 ->DONE. For reads, OPB_DO is sampled into PRDATA on the WAIT->DONE
//   edge (RD_WAIT cycles after strobe).
//  DONE: PREADY=1 for one cycle; ->IDLE. Back-to-back: next setup accepted the cycle after DONE.
//  Latency from setup cycle: write = 2+WR_WAIT cycles to PREADY; read = 2+RD_WAIT.
//  OPB_ADDR/OPB_DI hold last value between transfers; OPB_RE/OPB_WE never both 1 and never >1 cycle per transfer.
//  PRDATA holds last read value; writes leave it unchanged.
//  PSEL deasserted in STROBE/WAIT: abort to IDLE, no PREADY, no further strobe (strobe already issued stands).
//  Reset mid-transfer: outputs clear asynchronously; no PREADY issued for the lost transfer.
//  PADDR bits above ADDR_W ignored (aliased).
// CONFIGURATION
//  `OPB_BRIDGE_UNMAPPED_ERR_EN defined: OPB_HIT is sampled during STROBE.
//   If OPB_HIT=0: read returns PRDATA=32'hDEAD_BEEF (truncated to DATA_W).
//   PSLVERR=1 together with PREADY in DONE. Wait cycles still elapse.
//  Undefined: OPB_HIT ignored, PSLVERR tied 0, unmapped reads return whatever OPB_DO holds (normally 0).
// STRUCTURE
//  Package opb_bridge_pkg: state enum {IDLE,STROBE,WAIT,DONE}, OPB_ADDR_W=24, UNMAPPED_RDATA=32'hDEAD_BEEF,
//   WAIT_CNT_W=4.
//  Sub-module opb_wait_counter: load/decrement/zero-flag 4-bit down counter; FSM and datapath stay in top.
// TESTING
//  Reset held, random APB inputs -> all outputs 0; release -> IDLE, no strobes.
//  Write 0x060000 data 0x0000_00A5, WR_WAIT=0 -> OPB_WE 1 cycle with OPB_ADDR=0x060000,
//   OPB_DI=0xA5; PREADY 2 cycles after setup.
//  Read 0x070010, OPB_DO=0x1234 valid from strobe, RD_WAIT=2 -> OPB_RE 1 cycle; PRDATA=0x1234
//   with PREADY 4 cycles after setup.
//  Back-to-back write 0x0a0000 then read 0x0a1000 -> two separate strobes, no overlap,
//   second setup accepted the cycle after first PREADY.
//  PSEL dropped in WAIT, then reset asserted mid-read -> no PREADY; outputs 0 asynchronously;
//   next transfer completes normally.
//  Macro on, read 0x300000 with OPB_HIT=0 -> PRDATA=0xDEAD_BEEF, PSLVERR=1 with PREADY;
//   macro off -> PSLVERR=0.

Source files
------------

// File: rtl/opb_bridge_pkg.sv
// Shared types and constants for the APB-to-OPB bridge.
package opb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          OPB_ADDR_W     = 24;
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;
  localparam int          WAIT_CNT_W     = 4;

  // The counter signals zero on the last wait cycle, so it is loaded with cycles-1.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int cycles);
    if (cycles > 32'sd0) begin
      return WAIT_CNT_W'(cycles - 32'sd1);
    end else begin
      return {WAIT_CNT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/opb_wait_counter.sv
// Loadable 4-bit down counter with a registered zero flag, used to time
// the gap between an OPB strobe and the APB completion.
module opb_wait_counter
  import opb_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = {WAIT_CNT_W{1'b0}};
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

  logic [WAIT_CNT_W-1:0] cnt_r;
  logic [WAIT_CNT_W-1:0] cnt_nxt_s;
  logic                  zero_r;

  // Next count: load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = load_val;
    end else if (dec && !zero_r) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register and its zero flag, both registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_ZERO;
      zero_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_nxt_s;
      zero_r <= (cnt_nxt_s == CNT_ZERO);
    end
  end

  assign zero = zero_r;

endmodule

// File: rtl/apb_opb_bridge.sv
// APB3 slave that turns each transfer into one single-cycle OPB read or
// write strobe, then completes the APB access after a fixed wait count.
// Optional feature macro: OPB_BRIDGE_UNMAPPED_ERR_EN (OPB_HIT=0 gives
// PSLVERR and, for reads, the UNMAPPED_RDATA pattern).
module apb_opb_bridge
  import opb_bridge_pkg::*;
#(
  parameter int ADDR_W  = OPB_ADDR_W,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 0
) (
  input  logic              SYSCLK,
  input  logic              SYSRST_N,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [ADDR_W-1:0] OPB_ADDR,
  output logic [DATA_W-1:0] OPB_DI,
  output logic              OPB_RE,
  output logic              OPB_WE,
  input  logic [DATA_W-1:0] OPB_DO,
  input  logic              OPB_HIT
);

  localparam logic [WAIT_CNT_W-1:0] RD_LOAD     = wait_load(RD_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WR_LOAD     = wait_load(WR_WAIT);
  localparam logic                  RD_NO_WAIT  = (RD_WAIT <= 32'sd0);
  localparam logic                  WR_NO_WAIT  = (WR_WAIT <= 32'sd0);

  state_t              state_r;
  logic                dir_r;
  logic [ADDR_W-1:0]   opb_addr_r;
  logic [DATA_W-1:0]   opb_di_r;
  logic                opb_re_r;
  logic                opb_we_r;
  logic [DATA_W-1:0]   prdata_r;
  logic                pready_r;
  logic                cnt_load_s;
  logic [WAIT_CNT_W-1:0] cnt_val_s;
  logic                cnt_dec_s;
  logic                cnt_zero_s;
  logic                no_wait_s;
  logic                complete_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                unused_s;

  // PENABLE is not needed: the setup cycle alone starts the transfer.
  // Upper PADDR bits alias onto the OPB window.
  assign unused_s  = ^{PENABLE, PADDR[31:ADDR_W], OPB_HIT};
  assign no_wait_s = dir_r ? WR_NO_WAIT : RD_NO_WAIT;

`ifdef OPB_BRIDGE_UNMAPPED_ERR_EN
  localparam logic [DATA_W-1:0] UNMAPPED_DATA = DATA_W'(UNMAPPED_RDATA);

  logic hit_r;
  logic hit_now_s;
  logic pslverr_r;

  // Decoder hit is valid while the strobe is out; a zero-wait completion uses it live.
  assign hit_now_s = (state_r == STROBE) ? OPB_HIT : hit_r;
  assign rd_data_s = hit_now_s ? OPB_DO : UNMAPPED_DATA;

  // Remember whether the decoder claimed the strobed address.
  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      hit_r <= 1'b0;
    end else if (state_r == STROBE) begin
      hit_r <= OPB_HIT;
    end else begin
      hit_r <= hit_r;
    end
  end

  // Error response accompanies PREADY for unclaimed addresses.
  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      pslverr_r <= 1'b0;
    end else begin
      pslverr_r <= complete_s & ~hit_now_s;
    end
  end

  assign PSLVERR = pslverr_r;
`else
  assign rd_data_s = OPB_DO;
  assign PSLVERR   = 1'b0;
`endif

  // Counter control: load on the strobe cycle, count down while waiting.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_val_s  = RD_LOAD;
    cnt_dec_s  = 1'b0;
    case (state_r)
      STROBE: begin
        cnt_load_s = 1'b1;
        if (dir_r) begin
          cnt_val_s = WR_LOAD;
        end else begin
          cnt_val_s = RD_LOAD;
        end
      end
      WAIT: begin
        cnt_dec_s = 1'b1;
      end
      default: begin
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
      end
    endcase
  end

  // Transfer completes when the wait has elapsed and the master still selects us.
  always_comb begin
    complete_s = 1'b0;
    case (state_r)
      STROBE:  complete_s = PSEL & no_wait_s;
      WAIT:    complete_s = PSEL & cnt_zero_s;
      default: complete_s = 1'b0;
    endcase
  end

  opb_wait_counter u_wait_counter (
    .clk      (SYSCLK),
    .rst_n    (SYSRST_N),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Main sequencer: capture on setup, one strobe cycle, wait, then done.
  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      state_r    <= IDLE;
      dir_r      <= 1'b0;
      opb_addr_r <= {ADDR_W{1'b0}};
      opb_di_r   <= {DATA_W{1'b0}};
      opb_re_r   <= 1'b0;
      opb_we_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (PSEL) begin
            opb_addr_r <= PADDR[ADDR_W-1:0];
            opb_di_r   <= PWDATA;
            dir_r      <= PWRITE;
            opb_we_r   <= PWRITE;
            opb_re_r   <= ~PWRITE;
            state_r    <= STROBE;
          end else begin
            opb_we_r <= 1'b0;
            opb_re_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        STROBE: begin
          opb_we_r <= 1'b0;
          opb_re_r <= 1'b0;
          if (!PSEL) begin
            state_r <= IDLE;
          end else if (complete_s) begin
            state_r <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state_r <= IDLE;
          end else if (complete_s) begin
            state_r <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          opb_we_r <= 1'b0;
          opb_re_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          opb_we_r <= 1'b0;
          opb_re_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  // Completion outputs: one-cycle PREADY, read data captured only for reads.
  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      pready_r <= 1'b0;
      prdata_r <= {DATA_W{1'b0}};
    end else begin
      pready_r <= complete_s;
      if (complete_s && !dir_r) begin
        prdata_r <= rd_data_s;
      end else begin
        prdata_r <= prdata_r;
      end
    end
  end

  assign PRDATA   = prdata_r;
  assign PREADY   = pready_r;
  assign OPB_ADDR = opb_addr_r;
  assign OPB_DI   = opb_di_r;
  assign OPB_RE   = opb_re_r;
  assign OPB_WE   = opb_we_r;

endmodule

// File: tb/tb_apb_opb_bridge.sv
// Scoreboard bench for apb_opb_bridge: stimulus pushes expected strobes
// and responses, two monitors pop and compare as the DUT presents them.
module tb_apb_opb_bridge;

  localparam int RD_W = 2;
  localparam int WR_W = 0;
`ifdef OPB_BRIDGE_UNMAPPED_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          setup_c;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] di;
  } strb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [23:0] opb_addr;
  logic [31:0] opb_di, opb_do;
  logic        opb_re, opb_we, opb_hit;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  resp_t resp_q[$];
  strb_t strb_q[$];

  logic [31:0] periph_mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64]    = '{default: 32'h0};
  logic [31:0] ref_prdata = 32'h0;

  apb_opb_bridge #(.ADDR_W(24), .DATA_W(32), .RD_WAIT(RD_W), .WR_WAIT(WR_W)) dut (
    .SYSCLK(clk), .SYSRST_N(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .OPB_ADDR(opb_addr), .OPB_DI(opb_di), .OPB_RE(opb_re), .OPB_WE(opb_we),
    .OPB_DO(opb_do), .OPB_HIT(opb_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit mapped(input logic [23:0] a);
    return a[23:20] != 4'h3;
  endfunction

  // Peripheral model: 64 words, region 0x3xxxxx unclaimed.
  assign opb_hit = mapped(opb_addr);
  assign opb_do  = mapped(opb_addr) ? periph_mem[opb_addr[7:2]] : 32'h0;
  always @(posedge clk) if (opb_we && mapped(opb_addr)) periph_mem[opb_addr[7:2]] <= opb_di;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n === 1'b1 && pready === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("unexpected_pready", 32'(pready), 32'h0);
      end else begin
        r = resp_q.pop_front();
        check("prdata", prdata, r.prdata);
        check("pslverr", 32'(pslverr), 32'(r.slverr));
        check("latency", 32'(cyc - r.setup_c), 32'(r.lat));
      end
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    strb_t s;
    if (rst_n === 1'b1 && (opb_we === 1'b1 || opb_re === 1'b1)) begin
      check("strobe_exclusive", 32'(opb_we & opb_re), 32'h0);
      if (strb_q.size() == 0) begin
        check("unexpected_strobe", 32'(opb_we | opb_re), 32'h0);
      end else begin
        s = strb_q.pop_front();
        check("strobe_dir", 32'(opb_we), 32'(s.we));
        check("opb_addr", 32'(opb_addr), 32'(s.addr));
        check("opb_di", opb_di, s.di);
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data, input bit want_resp);
    resp_t r;
    strb_t s;
    logic [23:0] a;
    a = addr[23:0];
    s.we = wr; s.addr = a; s.di = data;
    strb_q.push_back(s);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'($urandom_range(0, 1));
    pwrite = wr; paddr = addr; pwdata = data;
    r.setup_c = cyc;
    r.lat = 2 + (wr ? WR_W : RD_W);
    r.slverr = ERR_EN && !mapped(a);
    if (wr) begin
      if (mapped(a)) ref_mem[a[7:2]] = data;
      r.prdata = ref_prdata;
    end else begin
      r.prdata = mapped(a) ? ref_mem[a[7:2]] : (ERR_EN ? 32'hDEAD_BEEF : 32'h0);
    end
    if (want_resp) begin
      if (!wr) ref_prdata = r.prdata;
      resp_q.push_back(r);
    end
  endtask

  task automatic complete();
    bit seen = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pready === 1'b1) seen = 1'b1;
    end
    check("pready_timeout", 32'(seen), 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'($urandom_range(0, 1));
      paddr = $urandom; pwdata = $urandom;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_prdata"}, prdata, 32'h0);
    check({tag, "_pready"}, 32'(pready), 32'h0);
    check({tag, "_pslverr"}, 32'(pslverr), 32'h0);
    check({tag, "_opb_addr"}, 32'(opb_addr), 32'h0);
    check({tag, "_opb_di"}, opb_di, 32'h0);
    check({tag, "_strobes"}, 32'({opb_re, opb_we}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    #2 rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      psel = 1'($urandom_range(0, 1)); penable = 1'($urandom_range(0, 1));
      pwrite = 1'($urandom_range(0, 1)); paddr = $urandom; pwdata = $urandom;
    end
    @(negedge clk); check_zero("rst_hold");
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    idle(3);
    @(negedge clk); check_zero("post_rst");

    // Directed write, then seed and read back a known word.
    issue(1'b1, 32'h0006_0000, 32'h0000_00A5, 1'b1); complete();
    issue(1'b1, 32'h0007_0010, 32'h0000_1234, 1'b1); complete();
    idle(2);
    issue(1'b0, 32'h0007_0010, $urandom, 1'b1); complete();
    idle(1);

    // Back-to-back write then read of the aliased word.
    issue(1'b1, 32'h000a_0000, 32'h5a5a_0001, 1'b1); complete();
    issue(1'b0, 32'h000a_1000, $urandom, 1'b1); complete();
    idle(2);

    // PSEL dropped during the wait: strobe stands, no completion.
    issue(1'b0, 32'h0007_0010, $urandom, 1'b0);
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    idle(6);
    check("abort_prdata_held", prdata, ref_prdata);

    // Reset asserted in the middle of a read.
    issue(1'b0, 32'h000a_1000, $urandom, 1'b0);
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; rst_n = 1'b0;
    #2; check_zero("async_rst");
    ref_prdata = 32'h0;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    issue(1'b0, 32'h0007_0010, $urandom, 1'b1); complete();
    idle(1);

    // Unclaimed region and aliased upper address bits.
    issue(1'b0, 32'h0030_0000, $urandom, 1'b1); complete();
    issue(1'b0, 32'hff07_0010, $urandom, 1'b1); complete();
    idle(1);

    // Randomised traffic with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = {8'($urandom), (($urandom_range(0, 3) == 0) ? 4'h3 : 4'($urandom)), 20'($urandom)};
      issue(w, a, $urandom, 1'b1);
      complete();
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("resp_q_drained", 32'(resp_q.size()), 32'h0);
    check("strb_q_drained", 32'(strb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
